// File: rtl/nios_rtc_pkg.sv
// Shared definitions for the BCD real-time clock: register addresses,
// per-field BCD limits, CONTROL bit layout and a BCD validity helper.
package nios_rtc_pkg;

  // Register map
  localparam logic [2:0] RTC_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] RTC_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] RTC_ADDR_MINSEC  = 3'd2;
  localparam logic [2:0] RTC_ADDR_HOUR    = 3'd3;
  localparam logic [2:0] RTC_ADDR_ALARM   = 3'd4;
  localparam logic [2:0] RTC_ADDR_WDAY    = 3'd5;

  // Largest legal value of each packed-BCD field
  localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;

  // CONTROL register bit positions
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ALARM_EN = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // CONTROL register as stored; field order matches the bit indices above
  typedef struct packed {
    logic irq_en;
    logic alarm_en;
    logic run;
  } rtc_ctrl_t;

  // Weekday counter wraps after this value
  localparam logic [2:0] WDAY_MAX = 3'd6;

  // A field is out of range when its low digit is not decimal or it exceeds
  // its maximum (a non-decimal high digit always exceeds the maximum).
  function automatic logic bcd_out_of_range(input logic [7:0] val,
                                            input logic [7:0] max);
    return (val[3:0] > 4'd9) || (val > max);
  endfunction

endpackage : nios_rtc_pkg

// File: rtl/rtc_bcd2_counter.sv
// One two-digit packed-BCD time field (seconds, minutes or hours).
// load has priority over inc. Incrementing the maximum value, or any
// out-of-range value, yields 8'h00 and raises carry_o for the next field.
// next_o exposes the value the field takes at the coming edge so the
// alarm comparator can look at the incremented time.
module rtc_bcd2_counter
  import nios_rtc_pkg::*;
#(
  parameter logic [7:0] MAX       = 8'h59,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] value_o,
  output logic [7:0] next_o,
  output logic       carry_o
);

  logic [7:0] value_q;
  logic [7:0] value_d;
  logic [7:0] inc_val;
  logic       wrap;

  // Incremented value of the field, with wrap-to-zero at max or on bad BCD
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    inc_val = 8'h00;
    wrap    = bcd_out_of_range(value_q, MAX) || (value_q == MAX);
    if (wrap) begin
      inc_val = 8'h00;
    end else if (value_q[3:0] == 4'd9) begin
      inc_val = {value_q[7:4] + 4'd1, 4'd0};
    end else begin
      inc_val = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  // Next-state select: bus load beats increment beats hold
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      value_d = inc_val;
    end
  end

  // Field register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign next_o  = value_d;
  assign carry_o = inc_i && !load_i && wrap;

endmodule : rtc_bcd2_counter

// File: rtl/nios_system_rtc_bcd.sv
// BCD time-of-day clock for the Nios system, advanced by the interval
// timer's one-cycle 1 Hz tick. Holds hh:mm:ss plus an hh:mm alarm with an
// interrupt, behind a 16-bit Avalon-MM slave with registered readdata.
// Optional feature: define RTC_WEEKDAY_EN to add a 0..6 weekday counter at
// register address 5, advanced on each midnight rollover.
module nios_system_rtc_bcd
  import nios_rtc_pkg::*;
#(
  parameter logic [23:0] RESET_HMS      = 24'h000000,
  parameter logic        RESET_RUN      = 1'b1,
  parameter logic [15:0] RESET_ALARM_HM = 16'h0700
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam rtc_ctrl_t CTRL_RESET = '{irq_en: 1'b0, alarm_en: 1'b0, run: RESET_RUN};

  logic        wr;
  logic        wr_minsec;
  logic        wr_hour;
  logic        tick_en;

  rtc_ctrl_t   ctrl_q, ctrl_d;
  logic [15:0] alarm_q, alarm_d;
  logic        alarm_flag_q, alarm_flag_d;
  logic [15:0] readdata_q, readdata_d;
  logic        alarm_match;

  logic [7:0]  sec_val, sec_next;
  logic [7:0]  min_val, min_next;
  logic [7:0]  hour_val, hour_next;
  logic        sec_carry, min_carry, hour_carry;
  logic [15:0] wday_rd;

  assign wr        = chipselect && !write_n;
  assign wr_minsec = wr && (address == RTC_ADDR_MINSEC);
  assign wr_hour   = wr && (address == RTC_ADDR_HOUR);

  // A time write in the tick cycle discards that tick for every field
  assign tick_en = tick && ctrl_q.run && !(wr_minsec || wr_hour);

  rtc_bcd2_counter #(
    .MAX       (BCD_SEC_MAX),
    .RESET_VAL (RESET_HMS[7:0])
  ) u_sec (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (tick_en),
    .load_i     (wr_minsec),
    .load_val_i (writedata[7:0]),
    .value_o    (sec_val),
    .next_o     (sec_next),
    .carry_o    (sec_carry)
  );

  rtc_bcd2_counter #(
    .MAX       (BCD_MIN_MAX),
    .RESET_VAL (RESET_HMS[15:8])
  ) u_min (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (sec_carry),
    .load_i     (wr_minsec),
    .load_val_i (writedata[15:8]),
    .value_o    (min_val),
    .next_o     (min_next),
    .carry_o    (min_carry)
  );

  rtc_bcd2_counter #(
    .MAX       (BCD_HOUR_MAX),
    .RESET_VAL (RESET_HMS[23:16])
  ) u_hour (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (min_carry),
    .load_i     (wr_hour),
    .load_val_i (writedata[7:0]),
    .value_o    (hour_val),
    .next_o     (hour_next),
    .carry_o    (hour_carry)
  );

  // Alarm fires when a counted tick lands exactly on hh:mm:00
  assign alarm_match = tick_en && ctrl_q.alarm_en &&
                       (sec_next  == 8'h00) &&
                       (min_next  == alarm_q[7:0]) &&
                       (hour_next == alarm_q[15:8]);

`ifdef RTC_WEEKDAY_EN
  logic [2:0] wday_q, wday_d;

  // Weekday next state: bus write beats the midnight carry; 6 and 7 wrap to 0
  always_comb begin
    wday_d = wday_q;
    if (wr && (address == RTC_ADDR_WDAY)) begin
      wday_d = writedata[2:0];
    end else if (hour_carry) begin
      wday_d = (wday_q >= WDAY_MAX) ? 3'd0 : wday_q + 3'd1;
    end
  end

  // Weekday register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wday_q <= 3'd0;
    end else begin
      wday_q <= wday_d;
    end
  end

  assign wday_rd = {13'b0, wday_q};
`else
  logic unused_hour_carry;
  assign unused_hour_carry = hour_carry;
  assign wday_rd           = 16'h0000;
`endif

  // Control, alarm and status-flag next state from bus writes and alarm match
  always_comb begin
    ctrl_d       = ctrl_q;
    alarm_d      = alarm_q;
    alarm_flag_d = alarm_flag_q;

    if (wr && (address == RTC_ADDR_CONTROL)) begin
      ctrl_d = rtc_ctrl_t'(writedata[2:0]);
    end
    if (wr && (address == RTC_ADDR_ALARM)) begin
      alarm_d = writedata;
    end

    // Setting the flag wins over a simultaneous STATUS-write clear
    if (alarm_match) begin
      alarm_flag_d = 1'b1;
    end else if (wr && (address == RTC_ADDR_STATUS)) begin
      alarm_flag_d = 1'b0;
    end
  end

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    readdata_d = 16'h0000;
    case (address)
      RTC_ADDR_STATUS:  readdata_d = {14'b0, ctrl_q.run, alarm_flag_q};
      RTC_ADDR_CONTROL: readdata_d = {13'b0, ctrl_q};
      RTC_ADDR_MINSEC:  readdata_d = {min_val, sec_val};
      RTC_ADDR_HOUR:    readdata_d = {8'b0, hour_val};
      RTC_ADDR_ALARM:   readdata_d = alarm_q;
      RTC_ADDR_WDAY:    readdata_d = wday_rd;
      default:          readdata_d = 16'h0000;
    endcase
  end

  // Register bank: control, alarm, alarm flag and registered read data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q       <= CTRL_RESET;
      alarm_q      <= RESET_ALARM_HM;
      alarm_flag_q <= 1'b0;
      readdata_q   <= 16'h0000;
    end else begin
      ctrl_q       <= ctrl_d;
      alarm_q      <= alarm_d;
      alarm_flag_q <= alarm_flag_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = alarm_flag_q && ctrl_q.irq_en;

endmodule : nios_system_rtc_bcd
